// File: rtl/mempool_pkg.sv
// Shared MemPool constants and helpers.
// Provides the requester-ID width for the TCDM bank arbiter at tile level.
package mempool_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NumTcdmArbIn  = 4;
  localparam int unsigned TcdmArbIdWidth = idx_width(NumTcdmArbIn);

endpackage

// File: rtl/tcdm_arb_id_fifo.sv
// Synchronous FIFO of requester IDs for in-order response routing.
// Full/empty flags are registered-count based; the head is never bypassed from data_i.
module tcdm_arb_id_fifo
  import mempool_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrWidth = idx_width(Depth);
  localparam logic [PtrWidth:0] DepthCnt = (PtrWidth + 1)'(Depth);

  logic [Depth-1:0][Width-1:0] mem_q;
  logic [PtrWidth-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PtrWidth:0]           count_q;
  logic                        do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin share of one TCDM bank adapter among NumIn requesters, in-order response demux.
// Define TCDM_ARB_PERF_EN to enable the saturating conflict/stall performance counters.
module tcdm_bank_arbiter
  import mempool_pkg::*;
#(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter type         metadata_t  = logic,
  parameter int unsigned IdFifoDepth = 4,
  parameter int unsigned BeWidth     = DataWidth / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic      [NumIn-1:0]               req_valid_i,
  output logic      [NumIn-1:0]               req_ready_o,
  input  logic      [NumIn-1:0][AddrWidth-1:0] req_addr_i,
  input  logic      [NumIn-1:0][3:0]          req_amo_i,
  input  logic      [NumIn-1:0]               req_write_i,
  input  logic      [NumIn-1:0][DataWidth-1:0] req_wdata_i,
  input  logic      [NumIn-1:0][BeWidth-1:0]  req_be_i,
  input  metadata_t [NumIn-1:0]               req_meta_i,
  output logic      [NumIn-1:0]               resp_valid_o,
  input  logic      [NumIn-1:0]               resp_ready_i,
  output logic      [DataWidth-1:0]           resp_rdata_o,
  output metadata_t                           resp_meta_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic      [AddrWidth-1:0]           out_addr_o,
  output logic      [3:0]                     out_amo_o,
  output logic                                out_write_o,
  output logic      [DataWidth-1:0]           out_wdata_o,
  output logic      [BeWidth-1:0]             out_be_o,
  output metadata_t                           out_meta_o,
  input  logic                                out_resp_valid_i,
  output logic                                out_resp_ready_o,
  input  logic      [DataWidth-1:0]           out_resp_rdata_i,
  input  metadata_t                           out_resp_meta_i,
  output logic      [31:0]                    perf_conflict_o,
  output logic      [31:0]                    perf_stall_o
);

  localparam int unsigned IdWidth = idx_width(NumIn);

  logic [NumIn-1:0]   eligible;
  logic [IdWidth-1:0] rr_q, rr_d, winner, lock_id_q, head;
  logic               lock_q, found, req_hs, fifo_push, fifo_pop, fifo_full, fifo_empty;
  int unsigned        cand;

  assign eligible = req_valid_i & (req_write_i | {NumIn{~fifo_full}});

  // A stalled winner is pinned so a freed FIFO slot cannot reorder the scan mid-request.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    if (lock_q && eligible[lock_id_q]) begin
      winner = lock_id_q;
      found  = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NumIn; k++) begin
        cand = 32'(rr_q) + k;
        if (cand >= NumIn) cand = cand - NumIn;
        if (!found && eligible[cand]) begin
          found  = 1'b1;
          winner = IdWidth'(cand);
        end
      end
    end
  end

  assign out_valid_o = rst_ni & found;
  assign req_hs      = out_valid_o & out_ready_i;
  assign out_addr_o  = req_addr_i[winner];
  assign out_amo_o   = req_amo_i[winner];
  assign out_write_o = req_write_i[winner];
  assign out_wdata_o = req_wdata_i[winner];
  assign out_be_o    = req_be_i[winner];
  assign out_meta_o  = req_meta_i[winner];
  assign rr_d        = (winner == IdWidth'(NumIn - 1)) ? '0 : winner + 1'b1;
  assign fifo_push   = req_hs & ~out_write_o;

  always_comb begin
    req_ready_o = '0;
    if (out_valid_o) req_ready_o[winner] = out_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      if (req_hs) rr_q <= rr_d;
      lock_q    <= out_valid_o & ~out_ready_i;
      lock_id_q <= winner;
    end
  end

  tcdm_arb_id_fifo #(
    .Depth (IdFifoDepth),
    .Width (IdWidth)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (winner),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    resp_valid_o     = '0;
    out_resp_ready_o = 1'b0;
    if (rst_ni && !fifo_empty) begin
      resp_valid_o[head] = out_resp_valid_i;
      out_resp_ready_o   = resp_ready_i[head];
    end
  end

  assign fifo_pop     = out_resp_valid_i & out_resp_ready_o;
  assign resp_rdata_o = out_resp_rdata_i;
  assign resp_meta_o  = out_resp_meta_i;

`ifdef TCDM_ARB_PERF_EN
  logic [31:0] conflict_q, stall_q;
  int unsigned num_eligible;

  always_comb begin
    num_eligible = 0;
    for (int unsigned i = 0; i < NumIn; i++) num_eligible += 32'(eligible[i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      if (num_eligible >= 2 && conflict_q != '1) conflict_q <= conflict_q + 1'b1;
      if (out_valid_o && !out_ready_i && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  assign perf_conflict_o = conflict_q;
  assign perf_stall_o    = stall_q;
`else
  assign perf_conflict_o = 32'h0;
  assign perf_stall_o    = 32'h0;
`endif

`ifndef SYNTHESIS
  resp_without_request: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(out_resp_valid_i && fifo_empty));
`endif

endmodule

// File: doc/tcdm_bank_arbiter.md
Name: tcdm_bank_arbiter

Overview:
- Shares one TCDM bank adapter (valid/ready request side, valid/ready response side with metadata) between NumIn requesters, e.g. local cores plus remote-group ports of one tile.
- Round-robin arbitrates requests and tracks the requester ID of every request that expects a response.
- Routes in-order responses back to the issuing port.
- Metadata, AMO and LR/SC fields pass through untouched; reservation handling stays in the bank adapter.

Parameters:
- NumIn, 4, number of requester ports (≥2).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; only 32 supported.
- metadata_t, logic, opaque metadata type forwarded both ways.
- IdFifoDepth, 4, max outstanding response-expecting requests (power of two, ≥2).
- BeWidth, DataWidth/8, derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- req_valid_i  in  NumIn  request valid per port
- req_ready_o  out  NumIn  request grant per port
- req_addr_i  in  NumIn×AddrWidth  address
- req_amo_i  in  NumIn×4  AMO opcode
- req_write_i  in  NumIn  1 = store
- req_wdata_i  in  NumIn×DataWidth  write data
- req_be_i  in  NumIn×BeWidth  byte enable
- req_meta_i  in  NumIn×metadata_t  metadata
- resp_valid_o  out  NumIn  response valid per port
- resp_ready_i  in  NumIn  response ready per port
- resp_rdata_o  out  DataWidth  response data, broadcast to all ports
- resp_meta_o  out  metadata_t  response metadata, broadcast to all ports
- out_valid_o / out_ready_i  out/in  1  request handshake to the adapter
- out_addr_o, out_amo_o, out_write_o, out_wdata_o, out_be_o, out_meta_o  out  as above  selected request fields
- out_resp_valid_i / out_resp_ready_o  in/out  1  response handshake from the adapter
- out_resp_rdata_i, out_resp_meta_i  in  DataWidth/metadata_t  response data and metadata
- perf_conflict_o  out  32  cycles with ≥2 eligible requesters
- perf_stall_o  out  32  cycles with an eligible request held because out_ready_i=0

Behaviour:
- Eligibility: port i is eligible if req_valid_i[i] and (req_write_i[i]=1 or ID FIFO not full). A response is expected iff write=0; AMO, LR and SC are issued with write=0.
- Arbitration is combinational and same-cycle.
  - The winner is the first eligible port at or after rr_q, wrapping at NumIn.
  - out_valid_o = any eligible; out_* fields are muxed from the winner.
  - req_ready_o[winner] = out_ready_i; all other ready bits are 0.
- No combinational path from out_ready_i to the winner selection.
- On request handshake:
  - rr_q ← winner+1 mod NumIn.
  - If the request expects a response, push the winner ID into the ID FIFO.
  - With no handshake, rr_q holds, including when out_valid_o=1 and out_ready_i=0.
- Request stability: once out_valid_o rises, the winner is not switched while out_ready_i=0, unless the winner drops its valid. Requesters must hold valid, so in practice the winner is fixed until the handshake.
- Responses arrive in request order (single bank).
  - head = FIFO head ID; resp_valid_o[head] = out_resp_valid_i; other resp_valid_o bits are 0.
  - out_resp_ready_o = resp_ready_i[head] when the FIFO is non-empty, else 0.
  - Pop on response handshake.
- FIFO full: read/AMO requests are masked; writes are still granted. No same-cycle pop-then-push bypass.
- Simultaneous push and pop while not full: both take effect, count unchanged.
- FIFO empty with out_resp_valid_i=1 is a protocol error: assertion fires, all resp_valid_o stay 0.
- Latency: request 0 cycles (combinational through). Response 0 cycles (combinational demux).
- Reset: rr_q=0, FIFO empty, perf counters 0. All req_ready_o, resp_valid_o and out_valid_o are 0 while in reset. Reset mid-transaction discards outstanding IDs.
- Perf counters saturate at 2^32-1.

Optional Feature:
- TCDM_ARB_PERF_EN defined: perf_conflict_o and perf_stall_o count as specified.
- Not defined: both outputs tied to 32'h0 and no counter flops are instantiated. Arbitration and routing are identical either way.

Decomposition:
- mempool_pkg holds a new constant TcdmArbIdWidth = idx_width(NumIn) for tile-level use; no new typedefs, the adapter's metadata_t is reused.
- One sub-module: tcdm_arb_id_fifo, a synchronous FIFO of IDs with full/empty flags and no fall-through.
- The round-robin selection stays inline.

Test Plan:
- Ports 0–3 issue continuous reads, out_ready_i=1, responses returned one cycle later: grants go 0,1,2,3,0…; each resp_valid_o[i] matches its request order and carries the meta it sent.
- Ports 1 and 2 valid, rr_q=2, out_ready_i=0 for 3 cycles then 1: port 2 is held as winner with stable fields and perf_stall_o=3; then port 2 handshakes and rr_q=3.
- IdFifoDepth=4, 4 reads outstanding with no responses; port 0 read and port 1 write pending: port 1 write granted, port 0 blocked until one response pops, then granted next cycle.
- Port 3 AMOAdd (amo=4'h2, write=0) followed by a port 0 store: an ID is pushed only for port 3; the single response goes to resp_valid_o[3].
- resp_ready_i[head]=0 for 5 cycles: out_resp_ready_o=0 and the FIFO holds; release pops exactly one entry.
- rst_ni asserted with 2 outstanding IDs: after release the FIFO is empty, rr_q=0, all outputs 0, perf counters 0.
